noc_output_arbiter: RTL and testbench

- Downstream stage of the router input ports in the 2x2 mesh NoC. One instance per router output direction.
- Collects 14-bit flits from NUM_IN input ports and arbitrates round-robin at packet granularity (wormhole lock until eop).
- Buffers accepted flits in a small output FIFO and presents them on a valid/ready link.
- Flit format is the team standard: [13] reserved, [12:11] dst_addr, [10:9] pack_t, [8:1] payload, [0] eop.

---
 rtl/noc_pkg.sv | 28 ++
 rtl/noc_rr_arbiter.sv | 24 ++
 rtl/noc_output_arbiter.sv | 128 ++++++++++++
 tb/tb_noc_output_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, field positions and arbiter state encoding.
package noc_pkg;

   localparam int PKT_W = 14;
   localparam int GNT_W = 2;

   localparam int DST_MSB     = 12;
   localparam int DST_LSB     = 11;
   localparam int TYPE_MSB    = 10;
   localparam int TYPE_LSB    = 9;
   localparam int PAYLOAD_MSB = 8;
   localparam int PAYLOAD_LSB = 1;
   localparam int EOP_BIT     = 0;

   typedef struct packed {
      logic       rsv;
      logic [1:0] dst_addr;
      logic [1:0] pack_t;
      logic [7:0] payload;
      logic       eop;
   } flit_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational rotate-priority picker: the first request after last_grant wins.
module noc_rr_arbiter #(
   parameter int NUM_IN = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [IDX_W-1:0]  last_grant,
   output logic [IDX_W-1:0]  gnt_idx,
   output logic              gnt_any
);

   // Scan from the farthest candidate back to last_grant+1 so the nearest requester overwrites.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = NUM_IN; k >= 1; k--) begin
         if (req[(int'(last_grant) + k) % NUM_IN]) begin
            gnt_idx = IDX_W'((int'(last_grant) + k) % NUM_IN);
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_output_arbiter.sv
// Router output stage: packet-granular round-robin (wormhole lock until eop)
// feeding a small output FIFO on a valid/ready link.
// Handshake: a flit moves on any link exactly in the cycle where valid and ready
// are both high at the rising clock edge; valid never depends on ready.
module noc_output_arbiter
   import noc_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int PKT_W  = 14,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN*PKT_W-1:0]  in_packet,
   input  logic [NUM_IN-1:0]        in_valid,
   output logic [NUM_IN-1:0]        in_ready,
   output logic [PKT_W-1:0]         out_packet,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               grant_id,
   output logic                     busy,
   output logic [CNT_W-1:0]         pkt_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FCW   = $clog2(DEPTH + 1);

   arb_state_e        state_q;
   logic [GNT_W-1:0]  owner_q;
   logic [GNT_W-1:0]  last_grant_q;
   logic [CNT_W-1:0]  pkt_cnt_q;

   logic [PKT_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FCW-1:0]    count_q, count_d;

   logic [GNT_W-1:0]  gnt_idx;
   logic              gnt_any;
   logic [PKT_W-1:0]  in_flit;
   logic              push;
   logic              pop;

   noc_rr_arbiter #(
      .NUM_IN (NUM_IN),
      .IDX_W  (GNT_W)
   ) u_rr (
      .req        (in_valid),
      .last_grant (last_grant_q),
      .gnt_idx    (gnt_idx),
      .gnt_any    (gnt_any)
   );

   assign in_flit    = in_packet[owner_q*PKT_W +: PKT_W];
   assign push       = |(in_valid & in_ready);
   assign out_valid  = (count_q != '0);
   assign pop        = out_valid & out_ready;
   assign out_packet = out_valid ? mem_q[rd_ptr_q] : '0;
   assign grant_id   = owner_q;
   assign busy       = (state_q == LOCKED);
   assign pkt_count  = pkt_cnt_q;

   // Only the locked owner may send, and only while the registered count shows space.
   always_comb begin
      in_ready = '0;
      if (state_q == LOCKED && count_q != FCW'(DEPTH)) begin
         in_ready[owner_q] = 1'b1;
      end
   end

   // Arbitration FSM: pick in IDLE, hold the owner in LOCKED until its eop flit is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_grant_q <= GNT_W'(NUM_IN - 1);
         pkt_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_any) begin
                  owner_q <= gnt_idx;
                  state_q <= LOCKED;
               end
            end
            LOCKED: begin
               if (push && in_flit[EOP_BIT]) begin
                  pkt_cnt_q    <= pkt_cnt_q + CNT_W'(1);
                  last_grant_q <= owner_q;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // FIFO pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + FCW'(1);
      else if (pop && !push) count_d = count_q - FCW'(1);
   end

   // FIFO control registers; reset empties the queue and drops its contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage, written unchanged from the owner's input.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_flit;
   end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: per-input source queues, expected-output scoreboard,
// directed scenarios with hand-computed flit order.
module tb_noc_output_arbiter;
  import noc_pkg::*;

  localparam int W = 14;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [N*W-1:0] in_packet = '0;
  logic [N-1:0]   in_valid  = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_packet;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [1:0]     grant_id;
  logic           busy;
  logic [15:0]    pkt_count;

  noc_output_arbiter #(.NUM_IN(4), .PKT_W(14), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_packet(in_packet), .in_valid(in_valid), .in_ready(in_ready),
    .out_packet(out_packet), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count)
  );

  // ---------------- narrow-counter DUT for wrap check ----------------
  logic [N*W-1:0] w_in_packet = '0;
  logic [N-1:0]   w_in_valid  = '0;
  logic [N-1:0]   w_in_ready;
  logic [W-1:0]   w_out_packet;
  logic           w_out_valid;
  logic [1:0]     w_grant_id;
  logic           w_busy;
  logic [1:0]     w_pkt_count;

  noc_output_arbiter #(.NUM_IN(4), .PKT_W(14), .DEPTH(2), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .in_packet(w_in_packet), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .out_packet(w_out_packet), .out_valid(w_out_valid), .out_ready(1'b1),
    .grant_id(w_grant_id), .busy(w_busy), .pkt_count(w_pkt_count)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] src_q[N][$];
  logic [N-1:0] stall = '0;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [W-1:0] mk(input logic [1:0] dst, input logic [1:0] typ,
                                      input logic [7:0] pl, input logic eop);
    flit_t f;
    f.rsv = 1'b0; f.dst_addr = dst; f.pack_t = typ; f.payload = pl; f.eop = eop;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int src_pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || src_pending() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout, %0d flits outstanding, expected 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    stall = '0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- driver: presents head of each source queue ----------------
  initial begin : driver
    logic [N-1:0] fire;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !stall[i]) begin
          in_valid[i] = 1'b1;
          in_packet[i*W +: W] = src_q[i][0];
        end else begin
          in_valid[i] = 1'b0;
          in_packet[i*W +: W] = '0;
        end
      end
    end
  end

  // ---------------- monitor: compares every output transfer ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_flit: got %h, expected no output", out_packet);
      end else begin
        e = exp_q.pop_front();
        if (out_packet !== e) begin
          n_err++;
          $display("FAIL out_flit: got %h, expected %h", out_packet, e);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int t;
    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_count", pkt_count, 16'd0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_out_packet", out_packet, 14'h0);
    #1 rst = 1'b0;

    // T1: single-flit packet on input 2, latency check
    src_q[2].push_back(14'h0A55);
    exp_q.push_back(14'h0A55);
    @(negedge clk);
    check("t1_arb_cycle_ready", in_ready, 4'b0000);
    check("t1_arb_cycle_busy", busy, 1'b0);
    @(negedge clk);
    check("t1_cycle1_ready", in_ready, 4'b0100);
    check("t1_cycle1_busy", busy, 1'b1);
    check("t1_cycle1_grant", grant_id, 2'd2);
    @(negedge clk);
    check("t1_cycle2_valid", out_valid, 1'b1);
    check("t1_cycle2_packet", out_packet, 14'h0A55);
    check("t1_pkt_count", pkt_count, 16'd1);
    check("t1_grant_hold", grant_id, 2'd2);
    check("t1_idle_busy", busy, 1'b0);
    wait_drain("t1_drain");

    // T2: all four inputs with 3-flit packets; expected order 0,1,2,3 whole
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) begin
        src_q[i].push_back(mk(2'(i), 2'd1, 8'(8'h10 * (i + 1) + k), k == 2));
        exp_q.push_back(mk(2'(i), 2'd1, 8'(8'h10 * (i + 1) + k), k == 2));
      end
    wait_drain("t2_drain");
    check("t2_pkt_count", pkt_count, 16'd4);
    check("t2_last_grant", grant_id, 2'd3);

    // T3: owner 1 stalls mid-packet while input 3 waits
    do_reset();
    for (int k = 0; k < 3; k++) begin
      src_q[1].push_back(mk(2'd1, 2'd2, 8'(8'hA0 + k), k == 2));
      exp_q.push_back(mk(2'd1, 2'd2, 8'(8'hA0 + k), k == 2));
    end
    for (int k = 0; k < 2; k++) begin
      src_q[3].push_back(mk(2'd3, 2'd3, 8'(8'hC0 + k), k == 1));
      exp_q.push_back(mk(2'd3, 2'd3, 8'(8'hC0 + k), k == 1));
    end
    t = 0;
    while (src_q[1].size() > 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t3_first_flit_taken", src_q[1].size(), 2);
    #1 stall[1] = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("t3_stall_busy", busy, 1'b1);
      check("t3_stall_ready3", in_ready[3], 1'b0);
      check("t3_stall_grant", grant_id, 2'd1);
      @(negedge clk);
    end
    #1 stall[1] = 1'b0;
    wait_drain("t3_drain");
    check("t3_pkt_count", pkt_count, 16'd2);

    // T4: backpressure with a 4-flit packet on input 0
    do_reset();
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(mk(2'd0, 2'd0, 8'(8'h50 + k), k == 3));
      exp_q.push_back(mk(2'd0, 2'd0, 8'(8'h50 + k), k == 3));
    end
    repeat (8) @(negedge clk);
    check("t4_accepted", src_q[0].size(), 2);
    check("t4_full_ready", in_ready, 4'b0000);
    check("t4_full_busy", busy, 1'b1);
    check("t4_head_packet", out_packet, {2'b00, 2'b00, 8'h50, 1'b0});
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("t4_pop_cycle_ready", in_ready, 4'b0000);
    @(negedge clk);
    check("t4_after_pop_ready", in_ready, 4'b0001);
    check("t4_after_pop_valid", out_valid, 1'b1);
    @(negedge clk);
    check("t4_pushpop_ready", in_ready, 4'b0001);
    check("t4_pushpop_valid", out_valid, 1'b1);
    wait_drain("t4_drain");
    check("t4_pkt_count", pkt_count, 16'd1);

    // T5: reset while locked with one flit buffered
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) src_q[1].push_back(mk(2'd2, 2'd1, 8'(8'h70 + k), k == 2));
    t = 0;
    while (src_q[1].size() > 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t5_one_buffered", src_q[1].size(), 2);
    check("t5_locked", busy, 1'b1);
    check("t5_buffered_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    @(negedge clk);
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_ready", in_ready, 4'b0000);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_pkt_count", pkt_count, 16'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    src_q[0].push_back(mk(2'd0, 2'd1, 8'h11, 1'b1));
    src_q[3].push_back(mk(2'd3, 2'd1, 8'h33, 1'b1));
    exp_q.push_back(mk(2'd0, 2'd1, 8'h11, 1'b1));
    exp_q.push_back(mk(2'd3, 2'd1, 8'h33, 1'b1));
    wait_drain("t5_drain");
    check("t5_pkt_count", pkt_count, 16'd2);
    check("t5_last_grant", grant_id, 2'd3);

    // T6: counter wrap on the narrow-counter instance
    @(negedge clk);
    #1;
    w_in_packet[W-1:0] = mk(2'd0, 2'd0, 8'hEE, 1'b1);
    w_in_valid = 4'b0001;
    t = 0;
    while (w_pkt_count != 2'd3 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("t6_reach_max", w_pkt_count, 2'd3);
    t = 0;
    while (w_pkt_count == 2'd3 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t6_wrap_zero", w_pkt_count, 2'd0);
    #1 w_in_valid = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
